// File: rtl/writeback_pkg.sv
// Shared widths, constants and the MEM/WB bundle payload for the writeback stage.
package writeback_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_data;
  } mem_wb_t;

  // Result mux: load data or ALU result.
  function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t b);
    return b.memtoreg ? b.mem_data : b.alu_result;
  endfunction

  // Register writes to r0 never reach the register file.
  function automatic logic wb_write_en(input mem_wb_t b);
    return b.regwrite && (b.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_bypass_cmp.sv
// One writeback-to-decode bypass comparison for a single source register.
module wb_bypass_cmp
  import writeback_pkg::*;
(
  input  logic                  regwrite,
  input  logic [REG_ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [REG_ADDR_W-1:0] rs,
  output logic                  hit_c,
  output logic [DATA_W-1:0]     data_c
);

  always_comb begin
    hit_c  = regwrite && (writereg == rs) && (rs != REG_ZERO);
    data_c = hit_c ? writedata : DATA_W'(0);
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register driving the register file, with retire counter and
// optional decode bypass (enabled by defining WB_FORWARD_EN).
module writeback_stage
  import writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      retire_count,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic [DATA_W-1:0]     fwd2_data
);

  mem_wb_t bundle;

  assign bundle = '{regwrite:   in_regwrite,
                    memtoreg:   in_memtoreg,
                    rd:         in_rd,
                    alu_result: in_alu_result,
                    mem_data:   in_mem_data};

  // Flush beats stall beats capture; a held bundle never re-issues its write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite     <= 1'b0;
      writereg     <= REG_ZERO;
      writedata    <= DATA_W'(0);
      wb_valid     <= 1'b0;
      retire_count <= CNT_W'(0);
    end else if (flush) begin
      regwrite <= 1'b0;
      wb_valid <= 1'b0;
    end else if (stall) begin
      regwrite <= 1'b0;
    end else if (in_valid) begin
      regwrite     <= wb_write_en(bundle);
      writereg     <= bundle.rd;
      writedata    <= wb_select(bundle);
      wb_valid     <= 1'b1;
      retire_count <= retire_count + CNT_W'(1);
    end else begin
      regwrite <= 1'b0;
      wb_valid <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  wb_bypass_cmp u_cmp1 (
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .rs        (dec_rs1),
    .hit_c     (fwd1_hit),
    .data_c    (fwd1_data)
  );

  wb_bypass_cmp u_cmp2 (
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .rs        (dec_rs2),
    .hit_c     (fwd2_hit),
    .data_c    (fwd2_data)
  );
`else
  // Bypass compiled out: ports stay, outputs tied low, decode sources ignored.
  logic unused_dec_rs;
  assign unused_dec_rs = ^{dec_rs1, dec_rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = DATA_W'(0);
  assign fwd2_data = DATA_W'(0);
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset; the interface is: clk  input  1  stage clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  MEM/WB bundle present this cycle.
REQ-004 SHALL have: stall  input  1  hold stage contents.
REQ-005 SHALL have: flush  input  1  discard incoming bundle.
REQ-006 SHALL have: in_regwrite  input  1  instruction writes a register.
REQ-007 SHALL have: in_memtoreg  input  1  select load data, not ALU result.
REQ-008 SHALL have: in_rd  input  5  destination register.
REQ-009 SHALL have: in_alu_result  input  32  ALU result.
REQ-010 SHALL have: in_mem_data  input  32  load data.
REQ-011 SHALL have: dec_rs1, dec_rs2  input  5 each  decode-stage source registers.
REQ-012 SHALL have: regwrite  output  1  register-file write enable.
REQ-013 SHALL have: writereg  output  5  register-file write address.
REQ-014 SHALL have: writedata  output  32  register-file write data.
REQ-015 SHALL have: wb_valid  output  1  stage holds a live instruction.
REQ-016 SHALL have: retire_count  output  32  retired-instruction counter.
REQ-017 SHALL have: fwd1_hit, fwd2_hit  output  1 each; fwd1_data, fwd2_data  output  32 each  bypass to decode.

Function
REQ-018 Outputs regwrite, writereg, writedata, wb_valid SHALL be registered on rising clk, stable through the following falling edge, where the register file writes.
REQ-019 Latency SHALL be one cycle: bundle captured at rising edge N drives outputs from edge N until edge N+1.
REQ-020 Capture SHALL occur when in_valid=1, stall=0, flush=0: writedata = in_memtoreg ? in_mem_data : in_alu_result; writereg = in_rd; wb_valid = 1.
REQ-021 regwrite SHALL be in_regwrite AND (in_rd != 0) on capture; writes to r0 are always suppressed.
REQ-022 in_valid=0 with stall=0, flush=0 SHALL clear wb_valid and regwrite; writereg/writedata hold.
REQ-023 stall=1 (flush=0) SHALL hold writereg, writedata, wb_valid and force regwrite to 0 from the next edge, so no write repeats.
REQ-024 flush SHALL take priority over stall and in_valid: clears wb_valid and regwrite at the next edge.
REQ-025 retire_count SHALL increment by 1 on every capture (REQ-020), wrapping 0xFFFFFFFF -> 0; no increment on stall, flush or bubble.
REQ-026 Bypass SHALL be combinational: fwdN_hit = regwrite AND (writereg == dec_rsN) AND (dec_rsN != 0); fwdN_data = writedata when hit, else 0.

Reset
REQ-027 rst=1 SHALL asynchronously force regwrite=0, wb_valid=0, writereg=0, writedata=0, retire_count=0.
REQ-028 Reset asserted mid-stall or mid-write SHALL abandon the held bundle; the first capture after deassertion behaves as from power-up.

Configuration
REQ-029 Macro WB_FORWARD_EN SHALL gate the bypass logic: defined -> REQ-026 active; undefined -> fwd1_hit, fwd2_hit, fwd1_data, fwd2_data tied to 0, ports retained, and dec_rs1/dec_rs2 unused.

Structure
REQ-030 Package writeback_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, REG_ZERO=0 and the MEM/WB bundle typedef (regwrite, memtoreg, rd, alu_result, mem_data).
REQ-031 Sub-module wb_bypass_cmp SHALL implement one source comparison (REQ-026), instantiated twice, only under WB_FORWARD_EN.

Verification
REQ-032 Capture: in_valid=1, in_regwrite=1, in_memtoreg=0, in_rd=5, alu=0x0000_00AA -> next cycle regwrite=1, writereg=5, writedata=0xAA, retire_count=1.
REQ-033 Load select and r0: in_memtoreg=1, mem=0xDEAD_BEEF, in_rd=0 -> writedata=0xDEADBEEF, regwrite=0, wb_valid=1.
REQ-034 Stall then flush: capture rd=7, stall 3 cycles -> regwrite 1 then 0,0,0, writereg=7 held, retire_count unchanged; stall=1 with flush=1 -> wb_valid=0.
REQ-035 Wrap and reset: preload retire_count to 0xFFFFFFFF, capture -> 0; assert rst mid-cycle -> all outputs 0 immediately, without waiting for clk.
REQ-036 Bypass (WB_FORWARD_EN): writereg=9, regwrite=1, dec_rs1=9, dec_rs2=0 -> fwd1_hit=1, fwd1_data=writedata, fwd2_hit=0; macro undefined -> all fwd outputs 0.
